// File: rtl/vga_rect_arbiter.sv
// Arbitrates NUM_REQ solid-rectangle fill requests onto the VGA adapter pixel port, one pixel per clock.
// Define VGA_RECT_ARB_FIXED_PRIO_EN for fixed lowest-index priority; the default is round-robin.
module vga_rect_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SCR_W   = 160,
  parameter int SCR_H   = 120
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] rect_x,
  input  logic [7*NUM_REQ-1:0] rect_y,
  input  logic [8*NUM_REQ-1:0] rect_w,
  input  logic [7*NUM_REQ-1:0] rect_h,
  input  logic [6*NUM_REQ-1:0] rect_colour,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [5:0]           colour,
  output logic                 plot
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [8:0] SW9 = 9'(SCR_W);
  localparam logic [7:0] SH8 = 8'(SCR_H);

  typedef enum logic [1:0] {IDLE, GRANT, DRAW, DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] w;
    logic [6:0] h;
    logic [5:0] col;
  } rect_req_t;

  // Latched rectangle; cx/cy run one bit wider so x0+w / y0+h never wrap.
  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x_last;
    logic [7:0] y_last;
    logic [5:0] col;
  } rect_t;

  rect_req_t fld [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fld
    assign fld[i] = {rect_x[8*i +: 8], rect_y[7*i +: 7], rect_w[8*i +: 8],
                     rect_h[7*i +: 7], rect_colour[6*i +: 6]};
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  rect_t            rect_q, rect_d;
  logic [8:0]       cx_q, cx_d;
  logic [7:0]       cy_q, cy_d;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic             busy_d, plot_d;
  logic [7:0]       x_d;
  logic [6:0]       y_d;
  logic [5:0]       colour_d;
  rect_req_t        sel;

  // Round-robin pick: rotate req so the pointer lands on bit 0, take the first set bit.
  logic [NUM_REQ-1:0] req_rot;
  logic [IW-1:0]      rot_off;
  logic               found;
  logic [IW:0]        win_sum;
  logic [IW-1:0]      pick;

  always_comb begin
    req_rot = NUM_REQ'({req, req} >> ptr_q);
    rot_off = '0;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        rot_off = IW'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, rot_off};
    pick    = (win_sum >= IW1'(NUM_REQ)) ? IW'(win_sum - IW1'(NUM_REQ)) : IW'(win_sum);
  end

  assign sel = fld[win_q];

`ifndef VGA_RECT_ARB_FIXED_PRIO_EN
  logic [IW:0] ptr_inc;
  assign ptr_inc = {1'b0, win_q} + IW1'(1);
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    rect_d   = rect_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = busy;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = pick;
          gnt_d   = ONE << pick;
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        rect_d.x0     = {1'b0, sel.x};
        rect_d.x_last = {1'b0, sel.x} + {1'b0, sel.w} - 9'd1;
        rect_d.y_last = {1'b0, sel.y} + {1'b0, sel.h} - 8'd1;
        rect_d.col    = sel.col;
        cx_d          = {1'b0, sel.x};
        cy_d          = {1'b0, sel.y};
        if (sel.w == '0 || sel.h == '0) begin
          done_d  = ONE << win_q;
          state_d = DONE;
        end else begin
          x_d      = sel.x;
          y_d      = sel.y;
          colour_d = sel.col;
          plot_d   = ({1'b0, sel.x} < SW9) && ({1'b0, sel.y} < SH8);
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (cx_q == rect_q.x_last && cy_q == rect_q.y_last) begin
          done_d  = ONE << win_q;
          state_d = DONE;
        end else begin
          if (cx_q == rect_q.x_last) begin
            cx_d = rect_q.x0;
            cy_d = cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
          x_d    = cx_d[7:0];
          y_d    = cy_d[6:0];
          plot_d = (cx_d < SW9) && (cy_d < SH8);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef VGA_RECT_ARB_FIXED_PRIO_EN
        ptr_d   = '0;
`else
        ptr_d   = (ptr_inc == IW1'(NUM_REQ)) ? '0 : IW'(ptr_inc);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= '0;
      rect_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      rect_q  <= rect_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      plot    <= plot_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_arbiter.sv
// Directed bench for vga_rect_arbiter: table of single-rectangle jobs plus reset, late-change and fairness sequences.
module tb_vga_rect_arbiter;
  localparam int N = 4;

  logic               clock = 1'b0;
  logic               resetn = 1'b1;
  logic [N-1:0]       req = '0;
  logic [8*N-1:0]     rect_x = '0;
  logic [7*N-1:0]     rect_y = '0;
  logic [8*N-1:0]     rect_w = '0;
  logic [7*N-1:0]     rect_h = '0;
  logic [6*N-1:0]     rect_colour = '0;
  logic [N-1:0]       gnt, done;
  logic               busy, plot;
  logic [7:0]         x;
  logic [6:0]         y;
  logic [5:0]         colour;

  vga_rect_arbiter #(.NUM_REQ(N), .SCR_W(160), .SCR_H(120)) dut (
    .clock(clock), .resetn(resetn), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour), .gnt(gnt), .done(done), .busy(busy),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    string nm;
    int    idx, x0, y0, w, h, col;
    int    exp_plots;
    bit    late;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic set_fields(input int i, input int xx, input int yy, input int ww,
                            input int hh, input int cc);
    rect_x[8*i +: 8]      = 8'(xx);
    rect_y[7*i +: 7]      = 7'(yy);
    rect_w[8*i +: 8]      = 8'(ww);
    rect_h[7*i +: 7]      = 7'(hh);
    rect_colour[6*i +: 6] = 6'(cc);
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (gnt == '0 && lat < 20);
  endtask

  function automatic int gnt_idx(input logic [N-1:0] g);
    int r = -1;
    for (int k = 0; k < N; k++) if (g[k]) r = k;
    return r;
  endfunction

  task automatic run_rect(input vec_t v);
    int lat, plots, ex, ey;
    set_fields(v.idx, v.x0, v.y0, v.w, v.h, v.col);
    req = '0;
    req[v.idx] = 1'b1;
    wait_gnt(lat);
    chk({v.nm, " gnt_latency"}, lat, 1);
    chk({v.nm, " gnt"}, int'(gnt), 1 << v.idx);
    chk({v.nm, " busy_at_gnt"}, int'(busy), 1);
    req = '0;
    plots = 0;
    for (int k = 0; k < v.w * v.h; k++) begin
      @(negedge clock);
      ex = v.x0 + k % v.w;
      ey = v.y0 + k / v.w;
      chk($sformatf("%s px%0d x", v.nm, k), int'(x), ex % 256);
      chk($sformatf("%s px%0d y", v.nm, k), int'(y), ey % 128);
      chk($sformatf("%s px%0d colour", v.nm, k), int'(colour), v.col);
      chk($sformatf("%s px%0d plot", v.nm, k), int'(plot), (ex < 160 && ey < 120) ? 1 : 0);
      chk($sformatf("%s px%0d busy", v.nm, k), int'(busy), 1);
      plots += int'(plot);
      if (v.late && k == 0) set_fields(v.idx, 1, 1, 1, 1, 6'h03);
    end
    @(negedge clock);
    chk({v.nm, " done"}, int'(done), 1 << v.idx);
    chk({v.nm, " plot_in_done"}, int'(plot), 0);
    chk({v.nm, " busy_in_done"}, int'(busy), 1);
    @(negedge clock);
    chk({v.nm, " busy_after"}, int'(busy), 0);
    chk({v.nm, " done_after"}, int'(done), 0);
    chk({v.nm, " plot_count"}, plots, v.exp_plots);
  endtask

  vec_t vecs [8];

  initial begin
    int lat, prev_cyc, w, exp_w;
    bit done_seen;

    vecs[0] = '{"basic",   0,  10,  20, 3, 2, 6'h30, 6, 1'b0};
    vecs[1] = '{"zero_w",  1,   5,   5, 0, 5, 6'h0C, 0, 1'b0};
    vecs[2] = '{"clip",    2, 158, 119, 4, 2, 6'h3F, 2, 1'b0};
    vecs[3] = '{"single",  3,   0,   0, 1, 1, 6'h01, 1, 1'b0};
    vecs[4] = '{"edge_x",  1, 159,   0, 2, 3, 6'h15, 3, 1'b0};
    vecs[5] = '{"offscr",  0, 250, 126, 6, 1, 6'h2A, 0, 1'b0};
    vecs[6] = '{"zero_h",  2,   7,   3, 2, 0, 6'h11, 0, 1'b0};
    vecs[7] = '{"late",    1,  40,  50, 4, 3, 6'h30, 12, 1'b1};

    #2 resetn = 1'b0;
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset plot", int'(plot), 0);
    chk("reset gnt", int'(gnt), 0);
    chk("reset done", int'(done), 0);
    chk("reset x", int'(x), 0);
    chk("reset y", int'(y), 0);
    chk("reset colour", int'(colour), 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_rect(vecs[i]);

    // Reset asserted mid-draw, between clock edges.
    set_fields(2, 20, 30, 10, 10, 6'h2A);
    req = 4'b0100;
    wait_gnt(lat);
    chk("rst_mid gnt", int'(gnt), 4);
    req = '0;
    repeat (5) @(negedge clock);
    chk("rst_mid px5 plot", int'(plot), 1);
    chk("rst_mid px5 x", int'(x), 24);
    #3 resetn = 1'b0;
    #1;
    chk("rst_mid plot", int'(plot), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid gnt_low", int'(gnt), 0);
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (done != '0) done_seen = 1'b1;
    end
    chk("rst_mid no_done", int'(done_seen), 0);

    // All requesters held high: grant order reveals the pointer policy.
    for (int i = 0; i < N; i++) set_fields(i, i, 0, 1, 1, i + 1);
    resetn = 1'b1;
    req = 4'b1111;
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(lat);
      w = gnt_idx(gnt);
`ifdef VGA_RECT_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = g % N;
`endif
      chk($sformatf("rr grant%0d winner", g), w, exp_w);
      chk($sformatf("rr grant%0d onehot", g), int'($onehot(gnt)), 1);
      if (g > 0) chk($sformatf("rr grant%0d gap", g), cyc - prev_cyc, 4);
      prev_cyc = cyc;
    end
    req = '0;
    lat = 0;
    while (busy && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    chk("final idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
